// File: rtl/tis100_pkg.sv
// rtl/tis100_pkg.sv - TIS-100 opcode, field layout, program depth and immediate limits
package tis100_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_MOV, OP_SWP, OP_SAV, OP_ADD, OP_SUB, OP_NEG,
      OP_JMP, OP_JEZ, OP_JNZ, OP_JGZ, OP_JLZ, OP_JRO
   } opcode_e;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} load_state_e;

   localparam int INSTR_W = 4;
   localparam int SRC_W   = 3;
   localparam int CONST_W = 11;
   localparam int DST_W   = 3;
   localparam int WORD_W  = INSTR_W + SRC_W + CONST_W + DST_W;

   localparam int DST_LSB   = 0;
   localparam int CONST_LSB = DST_LSB + DST_W;
   localparam int SRC_LSB   = CONST_LSB + CONST_W;
   localparam int INSTR_LSB = SRC_LSB + SRC_W;

   localparam int PROG_DEPTH = 15;

   localparam logic signed [CONST_W-1:0] CONST_MIN = -11'sd999;
   localparam logic signed [CONST_W-1:0] CONST_MAX = 11'sd999;

   // Opcodes above JRO (13..15) have no decoder meaning.
   function automatic logic op_legal(input logic [INSTR_W-1:0] instr);
      return instr <= OP_JRO;
   endfunction

endpackage

// File: rtl/op_encode.sv
// rtl/op_encode.sv - packs instruction fields into one program word (inverse of the node decoder)
module op_encode
   import tis100_pkg::*;
(
   input  logic [INSTR_W-1:0]        i_instr,
   input  logic [SRC_W-1:0]          i_src,
   input  logic signed [CONST_W-1:0] i_const,
   input  logic [DST_W-1:0]          i_dst,
   output logic [WORD_W-1:0]         o_word
);

   always_comb begin
      o_word                          = '0;
      o_word[INSTR_LSB +: INSTR_W]    = i_instr;
      o_word[SRC_LSB   +: SRC_W]      = i_src;
      o_word[CONST_LSB +: CONST_W]    = i_const;
      o_word[DST_LSB   +: DST_W]      = i_dst;
   end

endmodule

// File: rtl/op_encode_loader.sv
// rtl/op_encode_loader.sv - program loader FSM writing encoded ops to program memory
// Optional immediate range check enabled by OP_ENCODE_RANGE_CHECK_EN.
module op_encode_loader
   import tis100_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      finish,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INSTR_W-1:0]        in_instr,
   input  logic [SRC_W-1:0]          in_src,
   input  logic signed [CONST_W-1:0] in_const,
   input  logic [DST_W-1:0]          in_dst,
   output logic                      wr_en,
   output logic [3:0]                wr_addr,
   output logic [WORD_W-1:0]         wr_data,
   output logic [3:0]                prog_len,
   output logic                      done,
   output logic                      err
);

   localparam logic [3:0] LAST_IDX = 4'(PROG_DEPTH - 1);

   load_state_e       r_state, w_state_next;
   logic [3:0]        r_cnt;
   logic [3:0]        r_prog_len;
   logic              r_wr_en;
   logic [3:0]        r_wr_addr;
   logic [WORD_W-1:0] r_wr_data;
   logic [WORD_W-1:0] w_word;
   logic              w_accept;
   logic              w_bad;
   logic              w_last;

   op_encode u_op_encode (
      .i_instr (in_instr),
      .i_src   (in_src),
      .i_const (in_const),
      .i_dst   (in_dst),
      .o_word  (w_word)
   );

   assign in_ready = (r_state == ST_LOAD) && (r_cnt < 4'(PROG_DEPTH));
   // A coincident start restarts the load, so the beat is dropped.
   assign w_accept = in_valid && in_ready && !start;
   assign w_last   = (r_cnt == LAST_IDX);

`ifdef OP_ENCODE_RANGE_CHECK_EN
   assign w_bad = !op_legal(in_instr) || (in_const < CONST_MIN) || (in_const > CONST_MAX);
`else
   assign w_bad = !op_legal(in_instr);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (start) begin
         w_state_next = ST_LOAD;
      end else if (r_state == ST_LOAD) begin
         if (w_accept && w_bad)                w_state_next = ST_ERROR;
         else if ((w_accept && w_last) || finish) w_state_next = ST_DONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_prog_len <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (start) begin
            r_cnt      <= '0;
            r_prog_len <= '0;
         end else if (r_state == ST_LOAD) begin
            if (w_accept && w_bad) begin
               r_prog_len <= '0;
            end else begin
               if (w_accept) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_cnt;
                  r_wr_data <= w_word;
                  r_cnt     <= r_cnt + 4'd1;
               end
               // A word accepted alongside finish is counted before closing.
               if ((w_accept && w_last) || finish)
                  r_prog_len <= r_cnt + {3'b000, w_accept};
            end
         end
      end
   end

   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign prog_len = r_prog_len;
   assign done     = (r_state == ST_DONE);
   assign err      = (r_state == ST_ERROR);

endmodule
